// File: rtl/psram_arb_pkg.sv
// Shared definitions for the three-channel PSRAM arbiter: FSM encoding,
// channel indices and the default starvation threshold.
package psram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] CH_PIX = 2'd0;
   localparam logic [1:0] CH_AUD = 2'd1;
   localparam logic [1:0] CH_SYS = 2'd2;

   localparam int unsigned STARVE_LIMIT = 64;

   // Index of the set bit of a one-hot channel vector (ch0 when empty).
   function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
      logic [1:0] idx;
      idx = CH_PIX;
      if (oh[CH_SYS])
         idx = CH_SYS;
      else if (oh[CH_AUD])
         idx = CH_AUD;
      return idx;
   endfunction

endpackage

// File: rtl/psram_arb_pick.sv
// Winner selection for the PSRAM arbiter: starved ch2 first, then ch0,
// then ch1/ch2 round-robin. Owns the round-robin pointer and starvation counter.
module psram_arb_pick
   import psram_arb_pkg::*;
#(
   parameter int unsigned pStarveLimit = STARVE_LIMIT
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [2:0] iReq,
   input  logic       iGntSys,
   input  logic       iArb,
   output logic [2:0] oWin
);

   localparam int unsigned CW = $clog2(pStarveLimit + 1);

   logic          r_ptr_sys;
   logic [CW-1:0] r_starve;
   logic          w_starved;
   logic [2:0]    w_win;

   assign w_starved = (r_starve >= CW'(pStarveLimit));
   assign oWin      = w_win;

   always_comb begin
      w_win = '0;
      if (iReq[CH_SYS] && w_starved)
         w_win[CH_SYS] = 1'b1;
      else if (iReq[CH_PIX])
         w_win[CH_PIX] = 1'b1;
      else if (r_ptr_sys) begin
         if (iReq[CH_SYS])
            w_win[CH_SYS] = 1'b1;
         else if (iReq[CH_AUD])
            w_win[CH_AUD] = 1'b1;
      end else begin
         if (iReq[CH_AUD])
            w_win[CH_AUD] = 1'b1;
         else if (iReq[CH_SYS])
            w_win[CH_SYS] = 1'b1;
      end
   end

   // Pointer only moves on ch1/ch2 grants; a ch0 grant leaves it untouched.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         r_ptr_sys <= 1'b0;
         r_starve  <= '0;
      end else begin
         if (iArb && w_win[CH_AUD])
            r_ptr_sys <= 1'b1;
         else if (iArb && w_win[CH_SYS])
            r_ptr_sys <= 1'b0;

         if (iArb && w_win[CH_SYS])
            r_starve <= '0;
         else if (iReq[CH_SYS] && !iGntSys && !w_starved)
            r_starve <= r_starve + CW'(1);
      end
   end

endmodule

// File: rtl/psram_arbiter.sv
// Three-channel PSRAM arbiter: grants one requester at a time and steers its
// command, write data and read data to/from a single PSRAM controller.
module psram_arbiter
   import psram_arb_pkg::*;
#(
   parameter int unsigned pAddrWidth   = 23,
   parameter int unsigned pDataWidth   = 16,
   parameter int unsigned pLenWidth    = 8,
   parameter int unsigned pStarveLimit = STARVE_LIMIT
) (
   input  logic                    iClk,
   input  logic                    iRst,
   input  logic [2:0]              iReq,
   input  logic [2:0]              iWr,
   input  logic [3*pAddrWidth-1:0] iAddr,
   input  logic [3*pLenWidth-1:0]  iLen,
   input  logic [3*pDataWidth-1:0] iWd,
   output logic [2:0]              oGnt,
   output logic [2:0]              oWdRdy,
   output logic [2:0]              oRdVld,
   output logic [pDataWidth-1:0]   oRd,
   output logic [2:0]              oDone,
   output logic                    oMemReq,
   output logic                    oMemWr,
   output logic [pAddrWidth-1:0]   oMemAddr,
   output logic [pLenWidth-1:0]    oMemLen,
   output logic [pDataWidth-1:0]   oMemWd,
   input  logic                    iMemAck,
   input  logic                    iMemWdRdy,
   input  logic                    iMemRdVld,
   input  logic [pDataWidth-1:0]   iMemRd,
   input  logic                    iMemDone
);

   logic [1:0]            r_rst_sync;
   logic                  w_rst_n;
   state_t                r_state;
   state_t                w_next;
   logic [2:0]            r_gnt;
   logic                  r_wr;
   logic [pAddrWidth-1:0] r_addr;
   logic [pLenWidth-1:0]  r_len;
   logic [2:0]            w_win;
   logic                  w_arb;
   logic [1:0]            w_widx;
   logic [1:0]            w_gidx;
   logic [pDataWidth-1:0] w_gnt_wd;

   // Assertion is immediate; release takes two clock edges.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst)
         r_rst_sync <= '0;
      else
         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_arb    = (r_state == IDLE) && (|iReq);
   assign w_widx   = onehot_idx(w_win);
   assign w_gidx   = onehot_idx(r_gnt);
   assign w_gnt_wd = iWd[w_gidx*pDataWidth +: pDataWidth];

   psram_arb_pick #(
      .pStarveLimit (pStarveLimit)
   ) u_pick (
      .iClk    (iClk),
      .iRst    (w_rst_n),
      .iReq    (iReq),
      .iGntSys (r_gnt[CH_SYS]),
      .iArb    (w_arb),
      .oWin    (w_win)
   );

   always_ff @(posedge iClk or negedge w_rst_n) begin
      if (!w_rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (|iReq) w_next = CMD;
         CMD:     if (iMemAck) w_next = iMemDone ? DONE : XFER;
         XFER:    if (iMemDone) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_gnt  <= '0;
         r_wr   <= 1'b0;
         r_addr <= '0;
         r_len  <= '0;
      end else if (w_arb) begin
         r_gnt  <= w_win;
         r_wr   <= iWr[w_widx];
         r_addr <= iAddr[w_widx*pAddrWidth +: pAddrWidth];
         r_len  <= iLen[w_widx*pLenWidth +: pLenWidth];
      end else if (r_state == DONE) begin
         r_gnt  <= '0;
      end
   end

   assign oGnt     = r_gnt;
   assign oMemWr   = r_wr;
   assign oMemAddr = r_addr;
   assign oMemLen  = r_len;

   always_comb begin
      oMemReq = 1'b0;
      oWdRdy  = '0;
      oRdVld  = '0;
      oRd     = '0;
      oMemWd  = '0;
      oDone   = '0;
      case (r_state)
         CMD:  oMemReq = 1'b1;
         XFER: begin
            oWdRdy = r_gnt & {3{iMemWdRdy}};
            oRdVld = r_gnt & {3{iMemRdVld}};
            oRd    = iMemRd;
            oMemWd = w_gnt_wd;
         end
         DONE: oDone = r_gnt;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: table-driven arbitration and transfer
// vectors plus hand-written burst, round-robin, starvation and reset sequences.
module tb_psram_arbiter;

   logic        iClk;
   logic        iRst;
   logic [2:0]  iReq;
   logic [2:0]  iWr;
   logic [68:0] iAddr;
   logic [23:0] iLen;
   logic [47:0] iWd;
   logic [2:0]  oGnt;
   logic [2:0]  oWdRdy;
   logic [2:0]  oRdVld;
   logic [15:0] oRd;
   logic [2:0]  oDone;
   logic        oMemReq;
   logic        oMemWr;
   logic [22:0] oMemAddr;
   logic [7:0]  oMemLen;
   logic [15:0] oMemWd;
   logic        iMemAck;
   logic        iMemWdRdy;
   logic        iMemRdVld;
   logic [15:0] iMemRd;
   logic        iMemDone;

   psram_arbiter #(
      .pAddrWidth   (23),
      .pDataWidth   (16),
      .pLenWidth    (8),
      .pStarveLimit (64)
   ) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iReq      (iReq),
      .iWr       (iWr),
      .iAddr     (iAddr),
      .iLen      (iLen),
      .iWd       (iWd),
      .oGnt      (oGnt),
      .oWdRdy    (oWdRdy),
      .oRdVld    (oRdVld),
      .oRd       (oRd),
      .oDone     (oDone),
      .oMemReq   (oMemReq),
      .oMemWr    (oMemWr),
      .oMemAddr  (oMemAddr),
      .oMemLen   (oMemLen),
      .oMemWd    (oMemWd),
      .iMemAck   (iMemAck),
      .iMemWdRdy (iMemWdRdy),
      .iMemRdVld (iMemRdVld),
      .iMemRd    (iMemRd),
      .iMemDone  (iMemDone)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int n_chk  = 0;
   int n_pass = 0;

   // Monitors: per-channel done-pulse counts and the sequence of new grants.
   int         done_cnt [3];
   logic [2:0] g_log [$];
   logic [2:0] prev_gnt = '0;

   initial begin
      for (int c = 0; c < 3; c++) done_cnt[c] = 0;
   end

   always @(negedge iClk) begin
      for (int c = 0; c < 3; c++)
         if (oDone[c]) done_cnt[c]++;
      if (oGnt != 3'b000 && prev_gnt == 3'b000)
         g_log.push_back(oGnt);
      prev_gnt = oGnt;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic clear_inputs();
      iReq      = '0;
      iWr       = '0;
      iAddr     = '0;
      iLen      = '0;
      iWd       = '0;
      iMemAck   = 1'b0;
      iMemWdRdy = 1'b0;
      iMemRdVld = 1'b0;
      iMemRd    = '0;
      iMemDone  = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      iRst = 1'b0;
      repeat (2) tick();
      iRst = 1'b1;
      repeat (3) tick();
   endtask

   typedef struct packed {
      logic [2:0]  req;
      logic [2:0]  gnt;
      logic        mreq;
      logic [22:0] addr;
      logic [7:0]  len;
      logic        wr;
   } arb_vec_t;

   typedef struct packed {
      logic        wrdy;
      logic        rvld;
      logic [15:0] rd;
      logic [15:0] wd;
      logic [2:0]  e_wrdy;
      logic [2:0]  e_rvld;
      logic [15:0] e_rd;
      logic [15:0] e_wd;
   } xf_vec_t;

   arb_vec_t arb_tab [8];
   xf_vec_t  xf_tab  [7];

   initial begin : main
      int pulses;
      int d0;
      int d1;

      // Fresh arbiter (pointer at ch1, no starvation): priority ch0 > ch1 > ch2.
      arb_tab[0] = '{3'b000, 3'b000, 1'b0, 23'h000000, 8'h00, 1'b0};
      arb_tab[1] = '{3'b001, 3'b001, 1'b1, 23'h000100, 8'h07, 1'b0};
      arb_tab[2] = '{3'b010, 3'b010, 1'b1, 23'h200000, 8'h00, 1'b1};
      arb_tab[3] = '{3'b100, 3'b100, 1'b1, 23'h7FFFFF, 8'hFF, 1'b1};
      arb_tab[4] = '{3'b011, 3'b001, 1'b1, 23'h000100, 8'h07, 1'b0};
      arb_tab[5] = '{3'b101, 3'b001, 1'b1, 23'h000100, 8'h07, 1'b0};
      arb_tab[6] = '{3'b110, 3'b010, 1'b1, 23'h200000, 8'h00, 1'b1};
      arb_tab[7] = '{3'b111, 3'b001, 1'b1, 23'h000100, 8'h07, 1'b0};

      // ch2 write burst in XFER: strobes and data steered to ch2 only.
      xf_tab[0] = '{1'b1, 1'b0, 16'h0000, 16'h1234, 3'b100, 3'b000, 16'h0000, 16'h1234};
      xf_tab[1] = '{1'b0, 1'b0, 16'h0000, 16'h1234, 3'b000, 3'b000, 16'h0000, 16'h1234};
      xf_tab[2] = '{1'b1, 1'b0, 16'h0000, 16'h5678, 3'b100, 3'b000, 16'h0000, 16'h5678};
      xf_tab[3] = '{1'b0, 1'b1, 16'hBEEF, 16'h5678, 3'b000, 3'b100, 16'hBEEF, 16'h5678};
      xf_tab[4] = '{1'b1, 1'b0, 16'h0000, 16'h9ABC, 3'b100, 3'b000, 16'h0000, 16'h9ABC};
      xf_tab[5] = '{1'b0, 1'b0, 16'h0000, 16'h9ABC, 3'b000, 3'b000, 16'h0000, 16'h9ABC};
      xf_tab[6] = '{1'b1, 1'b0, 16'hDEF0, 16'h9ABC, 3'b100, 3'b000, 16'hDEF0, 16'h9ABC};

      clear_inputs();
      iRst = 1'b0;
      #3;
      chk("reset.gnt",  32'(oGnt),    32'h0);
      chk("reset.mreq", 32'(oMemReq), 32'h0);
      chk("reset.done", 32'(oDone),   32'h0);

      for (int i = 0; i < 8; i++) begin
         do_reset();
         iReq  = arb_tab[i].req;
         iWr   = 3'b110;
         iAddr = {23'h7FFFFF, 23'h200000, 23'h000100};
         iLen  = {8'hFF, 8'h00, 8'h07};
         tick();
         chk($sformatf("arb[%0d].gnt", i),  32'(oGnt),     32'(arb_tab[i].gnt));
         chk($sformatf("arb[%0d].mreq", i), 32'(oMemReq),  32'(arb_tab[i].mreq));
         chk($sformatf("arb[%0d].addr", i), 32'(oMemAddr), 32'(arb_tab[i].addr));
         chk($sformatf("arb[%0d].len", i),  32'(oMemLen),  32'(arb_tab[i].len));
         chk($sformatf("arb[%0d].wr", i),   32'(oMemWr),   32'(arb_tab[i].wr));
      end

      // ch2 write, len 3, toggling word-ready.
      do_reset();
      iReq  = 3'b100;
      iWr   = 3'b100;
      iAddr = {23'h7FFFF0, 23'h000000, 23'h000000};
      iLen  = {8'h03, 8'h00, 8'h00};
      tick();
      chk("wr.mreq", 32'(oMemReq), 32'h1);
      chk("wr.len",  32'(oMemLen), 32'h3);
      chk("wr.wr",   32'(oMemWr),  32'h1);
      iReq    = '0;
      iMemAck = 1'b1;
      tick();
      iMemAck = 1'b0;
      chk("wr.mreq_drop", 32'(oMemReq), 32'h0);
      pulses = 0;
      for (int i = 0; i < 7; i++) begin
         iMemWdRdy = xf_tab[i].wrdy;
         iMemRdVld = xf_tab[i].rvld;
         iMemRd    = xf_tab[i].rd;
         iWd       = {xf_tab[i].wd, 16'hAAAA, 16'h5555};
         #1;
         if (oWdRdy[2]) pulses++;
         chk($sformatf("xf[%0d].wdrdy", i), 32'(oWdRdy), 32'(xf_tab[i].e_wrdy));
         chk($sformatf("xf[%0d].rdvld", i), 32'(oRdVld), 32'(xf_tab[i].e_rvld));
         chk($sformatf("xf[%0d].rd", i),    32'(oRd),    32'(xf_tab[i].e_rd));
         chk($sformatf("xf[%0d].memwd", i), 32'(oMemWd), 32'(xf_tab[i].e_wd));
         tick();
      end
      chk("wr.pulses", 32'(pulses), 32'd4);
      iMemWdRdy = 1'b0;
      iMemDone  = 1'b1;
      #1;
      chk("wr.done_pre", 32'(oDone), 32'h0);
      tick();
      iMemDone = 1'b0;
      chk("wr.done", 32'(oDone), 32'b100);
      chk("wr.gnt_in_done", 32'(oGnt), 32'b100);
      tick();
      chk("wr.done_clr", 32'(oDone), 32'h0);
      chk("wr.gnt_clr",  32'(oGnt),  32'h0);

      // Stray controller signals while idle do nothing.
      iMemDone  = 1'b1;
      iMemRdVld = 1'b1;
      iMemRd    = 16'hFFFF;
      #1;
      chk("idle.rd", 32'(oRd), 32'h0);
      chk("idle.rdvld", 32'(oRdVld), 32'h0);
      tick();
      tick();
      chk("idle.done", 32'(oDone), 32'h0);
      chk("idle.gnt",  32'(oGnt),  32'h0);
      clear_inputs();

      // ch0 read of 8 words, ack after 2 cycles.
      do_reset();
      d0 = done_cnt[0];
      iReq  = 3'b001;
      iWr   = 3'b000;
      iAddr = {23'h0, 23'h0, 23'h000100};
      iLen  = {8'h0, 8'h0, 8'h07};
      tick();
      chk("rd.gnt",  32'(oGnt),     32'b001);
      chk("rd.addr", 32'(oMemAddr), 32'h000100);
      chk("rd.len",  32'(oMemLen),  32'h7);
      iReq = '0;
      tick();
      tick();
      chk("rd.mreq_hold", 32'(oMemReq),  32'h1);
      chk("rd.addr_hold", 32'(oMemAddr), 32'h000100);
      iMemAck = 1'b1;
      tick();
      iMemAck = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         iMemRdVld = 1'b1;
         iMemRd    = 16'hC000 + 16'(i);
         #1;
         if (oRdVld[0]) pulses++;
         chk($sformatf("rd.word%0d", i), 32'(oRd), 32'hC000 + 32'(i));
         tick();
      end
      iMemRdVld = 1'b0;
      iMemDone  = 1'b1;
      tick();
      iMemDone = 1'b0;
      tick();
      tick();
      chk("rd.pulses", 32'(pulses), 32'd8);
      chk("rd.done_cnt", 32'(done_cnt[0] - d0), 32'd1);
      chk("rd.gnt_clr", 32'(oGnt), 32'h0);

      // ch1 and ch2 continuous: alternate starting with ch1.
      do_reset();
      g_log.delete();
      iMemAck  = 1'b1;
      iMemDone = 1'b1;
      iReq     = 3'b110;
      for (int i = 0; i < 40 && g_log.size() < 4; i++) tick();
      chk("rr.count", 32'(g_log.size() >= 4), 32'h1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr.gnt%0d", i), 32'(i < g_log.size() ? g_log[i] : 3'b000),
             (i % 2 == 0) ? 32'b010 : 32'b100);

      // ch0 continuous starves ch2: 22 ch0 grants, then ch2, then ch0.
      do_reset();
      g_log.delete();
      iMemAck  = 1'b1;
      iMemDone = 1'b1;
      iReq     = 3'b101;
      for (int i = 0; i < 200 && g_log.size() < 24; i++) begin
         tick();
         if (oGnt[2]) iReq = 3'b001;
      end
      chk("starve.count", 32'(g_log.size() >= 24), 32'h1);
      chk("starve.last_ch0", 32'(g_log.size() > 21 ? g_log[21] : 3'b000), 32'b001);
      chk("starve.ch2",      32'(g_log.size() > 22 ? g_log[22] : 3'b000), 32'b100);
      chk("starve.resume",   32'(g_log.size() > 23 ? g_log[23] : 3'b000), 32'b001);

      // Reset during XFER.
      do_reset();
      iReq = 3'b010;
      tick();
      iReq    = '0;
      iMemAck = 1'b1;
      tick();
      iMemAck   = 1'b0;
      iMemRdVld = 1'b1;
      iMemWdRdy = 1'b1;
      #1;
      chk("rst.rdvld_pre", 32'(oRdVld), 32'b010);
      d1 = done_cnt[1];
      #1;
      iRst = 1'b0;
      #1;
      chk("rst.gnt",   32'(oGnt),    32'h0);
      chk("rst.rdvld", 32'(oRdVld),  32'h0);
      chk("rst.wdrdy", 32'(oWdRdy),  32'h0);
      chk("rst.mreq",  32'(oMemReq), 32'h0);
      chk("rst.addr",  32'(oMemAddr), 32'h0);
      iMemDone = 1'b1;
      tick();
      tick();
      clear_inputs();
      iRst = 1'b1;
      repeat (3) tick();
      chk("rst.no_done", 32'(done_cnt[1] - d1), 32'd0);
      iReq = 3'b110;
      tick();
      chk("rst.regrant", 32'(oGnt), 32'b010);
      iReq = '0;

      // Ack and done together in CMD.
      do_reset();
      d1   = done_cnt[1];
      iReq = 3'b010;
      tick();
      iReq     = '0;
      iMemAck  = 1'b1;
      iMemDone = 1'b1;
      #1;
      chk("ackdone.pre", 32'(oDone), 32'h0);
      tick();
      iMemAck  = 1'b0;
      iMemDone = 1'b0;
      chk("ackdone.done", 32'(oDone), 32'b010);
      chk("ackdone.gnt",  32'(oGnt),  32'b010);
      chk("ackdone.mreq", 32'(oMemReq), 32'h0);
      tick();
      chk("ackdone.clr", 32'(oDone), 32'h0);
      chk("ackdone.gnt_clr", 32'(oGnt), 32'h0);
      tick();
      chk("ackdone.once", 32'(done_cnt[1] - d1), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 pAddrWidth, 23, word address width.
REQ-002 pDataWidth, 16, data word width.
REQ-003 pLenWidth, 8, burst length field (words minus 1).
REQ-004 pStarveLimit, 64, wait cycles before channel 2 is promoted above channel 0.
REQ-005 iClk  input  1  system clock; all state on rising edge.
REQ-006 iRst  input  1  asynchronous, active-low reset.
REQ-007 iReq  input  3  per-channel request: ch0 pixel fetch, ch1 audio, ch2 system.
REQ-008 iWr  input  3  per-channel write flag (1 = write, 0 = read).
REQ-009 iAddr  input  3*pAddrWidth  packed start addresses, ch0 in LSBs.
REQ-010 iLen  input  3*pLenWidth  packed burst lengths minus 1.
REQ-011 iWd  input  3*pDataWidth  packed write data.
REQ-012 oGnt  output  3  one-hot grant, held for the whole transaction.
REQ-013 oWdRdy  output  3  write-data accept strobe to the granted channel.
REQ-014 oRdVld  output  3  read-data valid to the granted channel.
REQ-015 oRd  output  pDataWidth  read data, broadcast to all channels.
REQ-016 oDone  output  3  one-cycle completion pulse.
REQ-017 oMemReq / oMemWr / oMemAddr / oMemLen / oMemWd  output  1/1/pAddrWidth/pLenWidth/pDataWidth  command and write data to the PSRAM controller.
REQ-018 iMemAck / iMemWdRdy / iMemRdVld / iMemRd / iMemDone  input  1/1/1/pDataWidth/1  controller handshake signals: command accepted, write word consumed, read word valid, read data, burst complete.

Function
REQ-019 The FSM SHALL have four states, IDLE, CMD, XFER and DONE, with transitions: IDLE->CMD on any iReq; CMD->XFER on iMemAck; XFER->DONE on iMemDone; DONE->IDLE unconditionally.
REQ-020 In IDLE with any iReq set, the block SHALL register the winner into oGnt and latch its iWr, iAddr and iLen; oGnt SHALL be visible one cycle after the iReq is sampled.
REQ-021 The priority order SHALL be: (1) ch2 if its starvation counter is at or above pStarveLimit, then (2) ch0, then (3) ch1/ch2 round-robin.
REQ-022 The round-robin pointer SHALL toggle to the other channel after a ch1 or ch2 grant; a ch0 grant SHALL NOT change the pointer.
REQ-023 The starvation counter SHALL increment on every cycle in which iReq[2] is set and oGnt[2] is clear, saturate at pStarveLimit, and clear on a ch2 grant.
REQ-024 In CMD, oMemReq SHALL be 1 with the latched fields and held stable until iMemAck; oMemReq SHALL drop in the cycle after ack.
REQ-025 In XFER, oWdRdy[g] SHALL equal iMemWdRdy, oMemWd SHALL equal iWd[g], oRdVld[g] SHALL equal iMemRdVld and oRd SHALL equal iMemRd, all combinationally; non-granted bits SHALL be 0.
REQ-026 If iMemAck and iMemDone are both 1 in CMD, the FSM SHALL go directly to DONE.
REQ-027 iMemDone outside XFER/CMD SHALL be ignored.
REQ-028 In DONE, oDone[g] SHALL pulse for one cycle, and oGnt SHALL clear at the end of DONE.
REQ-029 At least one IDLE cycle SHALL separate consecutive transactions.
REQ-030 Requesters SHALL hold iReq, iWr, iAddr and iLen stable until oGnt; iReq may drop after grant; an iReq withdrawn before grant SHALL NOT be granted.
REQ-031 An iReq held through DONE SHALL be treated as a new request.

Reset
REQ-032 iRst low SHALL asynchronously force: IDLE, all outputs 0, pointer = ch1, starvation counter = 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no oDone; release SHALL be synchronised to iClk.

Structure
REQ-034 Package psram_arb_pkg SHALL hold the state encoding, the channel index constants (CH_PIX=0, CH_AUD=1, CH_SYS=2) and the pStarveLimit default.
REQ-035 One sub-module, psram_arb_pick, SHALL hold the round-robin pointer, the starvation counter and the winner selection.
REQ-036 Target implementation size is 150-300 lines of RTL.

Verification
REQ-037 ch0 read, addr 0x000100, len 7; controller acks after 2 cycles and returns 8 words -> 8 oRdVld[0] pulses, one oDone[0], oGnt back to 000.
REQ-038 ch1 and ch2 request continuously, ch0 idle -> grants alternate 010,100,010,100.
REQ-039 ch0 requests continuously, ch2 requests, limit 64 -> ch2 granted at the first arbitration after 64 waiting cycles, then ch0 resumes.
REQ-040 ch2 write, len 3, iMemWdRdy toggling -> exactly 4 oWdRdy[2] pulses, oMemWd tracks iWd[2].
REQ-041 Reset asserted during XFER -> outputs 0 immediately; no oDone; next request after release is granted normally.
REQ-042 iMemAck and iMemDone asserted together in CMD -> DONE next cycle, oDone pulses once.
